// File: rtl/tx_axis_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one AXIS master (TX MAC input) among NUM_PORTS sources.
// state   | meaning: IDLE arbitrate | FORWARD pass granted frame | CLOSE emit abort beat | DRAIN discard rest of frame
module tx_axis_frame_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                 tx_clk,
    input  logic                                 tx_rst,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_tvalid,
    input  logic [NUM_PORTS-1:0]                 s_tlast,
    output logic [NUM_PORTS-1:0]                 s_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           m_tdata,
    output logic [AXIS_DATA_BYTES-1:0]           m_tkeep,
    output logic                                 m_tvalid,
    output logic                                 m_tlast,
    input  logic                                 m_tready,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic                                 busy,
    output logic [NUM_PORTS-1:0]                 frame_abort
);

    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_TO = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_TO - 1);
    localparam logic [WD_W-1:0] WD_SAT  = WD_W'(WD_TO);
    localparam logic [PW-1:0]   PTR_RST = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        CLOSE   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [NUM_PORTS-1:0]        grant_next;
    logic [PW-1:0]               ptr;
    logic [PW-1:0]               ptr_next;
    logic [WD_W-1:0]             wdog;
    logic [WD_W-1:0]             wdog_next;
    logic [NUM_PORTS-1:0]        abort_next;

    logic                        req_found;
    logic [PW-1:0]               win_idx;
    logic [PW-1:0]               cand;

    logic [AXIS_DATA_WIDTH-1:0]  sel_tdata;
    logic [AXIS_DATA_BYTES-1:0]  sel_tkeep;
    logic                        sel_tvalid;
    logic                        sel_tlast;

    // Search starts just after the last winner so a port that was just served goes last.
    always_comb begin
        req_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_PORTS);
            if (!req_found && s_tvalid[cand]) begin
                req_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_tdata = '0;
        sel_tkeep = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel_tdata = sel_tdata | s_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                sel_tkeep = sel_tkeep | s_tkeep[p*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
            end
        end
    end

    assign sel_tvalid = |(s_tvalid & grant);
    assign sel_tlast  = |(s_tlast & grant);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        wdog_next  = wdog;
        abort_next = '0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        m_tdata    = '0;
        m_tkeep    = '0;
        s_tready   = '0;
        case (state)
            IDLE: begin
                wdog_next = '0;
                if (req_found) begin
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    ptr_next            = win_idx;
                    state_next          = FORWARD;
                end
            end
            FORWARD: begin
                m_tvalid = sel_tvalid;
                m_tlast  = sel_tlast;
                m_tdata  = sel_tdata;
                m_tkeep  = sel_tkeep;
                s_tready = grant & {NUM_PORTS{m_tready}};
                if (sel_tvalid && m_tready) begin
                    wdog_next = '0;
                    if (sel_tlast) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else if (!sel_tvalid && (TIMEOUT_CYCLES > 0)) begin
                    // Only a silent source counts; MAC backpressure leaves the count untouched.
                    if (wdog == WD_LAST) begin
                        wdog_next  = WD_SAT;
                        abort_next = grant;
                        state_next = CLOSE;
                    end else begin
                        wdog_next = wdog + 1'b1;
                    end
                end
            end
            CLOSE: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                if (m_tready) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                s_tready = grant;
                if (sel_tvalid && sel_tlast) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_rst) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= PTR_RST;
            wdog        <= '0;
            frame_abort <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            ptr         <= ptr_next;
            wdog        <= wdog_next;
            frame_abort <= abort_next;
        end
    end

endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// Directed + randomized bench for tx_axis_frame_arbiter against a frame-queue round-robin model.
module tb_tx_axis_frame_arbiter;

    localparam int NP = 2;
    localparam int W  = 32;
    localparam int B  = 4;
    localparam int TO = 256;

    logic              tx_clk = 1'b0;
    logic              tx_rst;
    logic [NP*W-1:0]   s_tdata;
    logic [NP*B-1:0]   s_tkeep;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [W-1:0]      m_tdata;
    logic [B-1:0]      m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [NP-1:0]     grant;
    logic              busy;
    logic [NP-1:0]     frame_abort;

    tx_axis_frame_arbiter #(
        .NUM_PORTS(NP), .AXIS_DATA_WIDTH(W), .AXIS_DATA_BYTES(B), .TIMEOUT_CYCLES(TO)
    ) dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .grant(grant), .busy(busy), .frame_abort(frame_abort)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [W-1:0] data;
        logic [B-1:0] keep;
        logic         last;
        logic         close;
        int           hold_after;
    } beat_t;

    beat_t src_q [NP][$];
    beat_t exp_q [NP][$];

    int total = 0;
    int bad   = 0;
    int last_port, in_frame, exp_port, gap_state;
    int mid [NP];
    int hold [NP];
    int gap_en, rdy_mode;
    int abort_cycles, gcount, out_beats;
    logic [NP-1:0] abort_or;
    logic [NP-1:0] ord_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr_next();
        int c;
        for (int i = 1; i <= NP; i++) begin
            c = (last_port + i) % NP;
            if (exp_q[c].size() > 0) return c;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() > 0 || exp_q[p].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // A stall of at least TO idle cycles mid-frame turns the tail into one empty tlast beat.
    task automatic add_frame(input int p, input int len, input int stall_at, input int slen);
        beat_t b;
        bit    is_abort;
        is_abort = (stall_at > 0) && (stall_at < len) && (slen >= TO);
        for (int i = 0; i < len; i++) begin
            b.data       = $urandom;
            b.keep       = 4'($urandom_range(1, 15));
            b.last       = (i == len - 1);
            b.close      = 1'b0;
            b.hold_after = (i == stall_at - 1) ? slen : 0;
            src_q[p].push_back(b);
            if (!is_abort || i < stall_at) exp_q[p].push_back(b);
        end
        if (is_abort) begin
            b.data = '0; b.keep = '0; b.last = 1'b1; b.close = 1'b1; b.hold_after = 0;
            exp_q[p].push_back(b);
        end
    endtask

    task automatic monitor();
        beat_t b;
        if (frame_abort != '0) begin
            abort_cycles++;
            abort_or = abort_or | frame_abort;
        end
        if (grant != '0) gcount++;
        chk("ready_mask", 64'(s_tready & ~grant), 64'd0);
        if (gap_state == 1) begin
            chk("idle_grant", 64'(grant), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            gap_state = (rr_next() >= 0) ? 2 : 0;
        end else if (gap_state == 2) begin
            chk("rr_grant", 64'(grant), 64'(1) << rr_next());
            gap_state = 0;
        end
        if (m_tvalid && m_tready) begin
            if (!in_frame) begin
                exp_port = rr_next();
                in_frame = 1;
                ord_q.push_back(grant);
            end
            if (exp_port < 0 || exp_q[exp_port].size() == 0) begin
                chk("unexpected_beat", 64'(m_tvalid), 64'd0);
                in_frame = 0;
            end else begin
                b = exp_q[exp_port].pop_front();
                chk("beat_grant", 64'(grant), 64'(1) << exp_port);
                chk("m_tdata", 64'(m_tdata), 64'(b.data));
                chk("m_tkeep", 64'(m_tkeep), 64'(b.keep));
                chk("m_tlast", 64'(m_tlast), 64'(b.last));
                out_beats++;
                if (b.last) begin
                    in_frame  = 0;
                    last_port = exp_port;
                    gap_state = b.close ? 0 : 1;
                end
            end
        end
    endtask

    task automatic run_cycle();
        for (int p = 0; p < NP; p++) begin
            if (hold[p] > 0) begin
                s_tvalid[p] = 1'b0;
                hold[p]--;
            end else if (src_q[p].size() == 0) begin
                s_tvalid[p] = 1'b0;
            end else if (gap_en != 0 && mid[p] != 0 && $urandom_range(0, 3) == 0) begin
                s_tvalid[p] = 1'b0;
            end else begin
                s_tvalid[p] = 1'b1;
            end
            if (src_q[p].size() > 0) begin
                s_tdata[p*W +: W] = src_q[p][0].data;
                s_tkeep[p*B +: B] = src_q[p][0].keep;
                s_tlast[p]        = src_q[p][0].last;
            end else begin
                s_tdata[p*W +: W] = $urandom;
                s_tkeep[p*B +: B] = '0;
                s_tlast[p]        = 1'b0;
            end
        end
        if (rdy_mode == 0)      m_tready = ($urandom_range(0, 2) != 0);
        else if (rdy_mode == 1) m_tready = 1'b1;
        else                    m_tready = 1'b0;
        #1;
        monitor();
        for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && s_tready[p] && src_q[p].size() > 0) begin
                mid[p]  = src_q[p][0].last ? 0 : 1;
                hold[p] = src_q[p][0].hold_after;
                void'(src_q[p].pop_front());
            end
        end
        @(posedge tx_clk);
        #1;
    endtask

    task automatic run_to_empty(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_empty() && n < budget) begin
            run_cycle();
            n++;
        end
        chk(tag, 64'(all_empty()), 64'd1);
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            mid[p]  = 0;
            hold[p] = 0;
        end
        last_port = NP - 1;
        in_frame  = 0;
        gap_state = 0;
    endtask

    initial begin
        int n, ob, base;
        model_reset();
        gap_en = 0; rdy_mode = 1; abort_cycles = 0; gcount = 0; out_beats = 0; abort_or = '0;

        // 1: reset held with every source requesting
        tx_rst   = 1'b0;
        s_tvalid = '1;
        s_tlast  = '1;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = '1;
        m_tready = 1'b1;
        repeat (2) @(posedge tx_clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_abort", 64'(frame_abort), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        s_tvalid = '0;
        tx_rst   = 1'b1;

        // 2: both ports continuously requesting 3-beat frames
        add_frame(0, 3, 0, 0); add_frame(1, 3, 0, 0);
        add_frame(0, 3, 0, 0); add_frame(1, 3, 0, 0);
        run_to_empty("t2_done", 200);
        chk("t2_frames", 64'(ord_q.size()), 64'd4);
        if (ord_q.size() >= 4) begin
            chk("t2_order0", 64'(ord_q[0]), 64'd1);
            chk("t2_order1", 64'(ord_q[1]), 64'd2);
            chk("t2_order2", 64'(ord_q[2]), 64'd1);
            chk("t2_order3", 64'(ord_q[3]), 64'd2);
        end

        // 3: single-beat partial-keep frame from port 1
        begin
            beat_t b;
            b.data = $urandom; b.keep = 4'b1100; b.last = 1'b1; b.close = 1'b0; b.hold_after = 0;
            src_q[1].push_back(b);
            exp_q[1].push_back(b);
        end
        gcount = 0;
        ob     = out_beats;
        repeat (6) run_cycle();
        chk("t3_grant_cycles", 64'(gcount), 64'd1);
        chk("t3_beats", 64'(out_beats - ob), 64'd1);

        // 4: long MAC backpressure mid-frame is not a source stall
        add_frame(0, 4, 0, 0);
        ob = out_beats;
        n  = 0;
        while (out_beats < ob + 2 && n < 50) begin run_cycle(); n++; end
        chk("t4_two_beats", 64'(out_beats - ob), 64'd2);
        rdy_mode = 2;
        repeat (300) run_cycle();
        chk("t4_no_abort", 64'(abort_cycles), 64'd0);
        chk("t4_held_grant", 64'(grant), 64'd1);
        chk("t4_held_beats", 64'(out_beats - ob), 64'd2);
        rdy_mode = 1;
        run_to_empty("t4_done", 50);

        // 5a: stall one cycle short of the timeout completes normally
        add_frame(1, 4, 2, TO - 1);
        run_to_empty("t5a_done", 400);
        chk("t5a_no_abort", 64'(abort_cycles), 64'd0);

        // 5: stall of exactly the timeout aborts, tail drained, port 1 waits during drain
        add_frame(0, 5, 2, TO);
        n = 0;
        while (abort_cycles == 0 && n < 600) begin run_cycle(); n++; end
        chk("t5_abort_seen", 64'(abort_cycles), 64'd1);
        add_frame(1, 3, 0, 0);
        hold[0] = 5;
        run_cycle();
        run_cycle();
        chk("t5_drain_grant", 64'(grant), 64'd1);
        chk("t5_drain_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t5_drain_busy", 64'(busy), 64'd1);
        run_to_empty("t5_done", 100);
        chk("t5_abort_once", 64'(abort_cycles), 64'd1);
        chk("t5_abort_port", 64'(abort_or), 64'd1);

        // 6: reset while port 0 is on its second beat
        add_frame(0, 4, 0, 0);
        add_frame(1, 3, 0, 0);
        ob = out_beats;
        n  = 0;
        while (out_beats < ob + 1 && n < 20) begin run_cycle(); n++; end
        chk("t6_first_beat", 64'(out_beats - ob), 64'd1);
        tx_rst = 1'b0;
        run_cycle();
        tx_rst = 1'b1;
        chk("t6_grant", 64'(grant), 64'd0);
        chk("t6_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_s_tready", 64'(s_tready), 64'd0);
        model_reset();
        base = ord_q.size();
        add_frame(0, 2, 0, 0);
        add_frame(1, 2, 0, 0);
        run_to_empty("t6_done", 100);
        chk("t6_frames", 64'(ord_q.size() - base), 64'd2);
        if (ord_q.size() >= base + 2) begin
            chk("t6_first_port0", 64'(ord_q[base]), 64'd1);
            chk("t6_then_port1", 64'(ord_q[base + 1]), 64'd2);
        end

        // 7: random frames, random source gaps and MAC backpressure
        abort_cycles = 0;
        gap_en       = 1;
        rdy_mode     = 0;
        for (int f = 0; f < 24; f++) add_frame($urandom_range(0, NP - 1), $urandom_range(1, 6), 0, 0);
        run_to_empty("t7_done", 3000);
        chk("t7_no_abort", 64'(abort_cycles), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
